rom_fetch_unit: RTL

ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

---
 rtl/rom_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: prefetches bytes from a registered program ROM into a 2-entry buffer.
// Optional stall counter on STALL_CNT when FETCH_PERF_CNT_EN is defined.
module rom_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [7:0]            ROM_DATA,
  output logic [7:0]            INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  BRANCH_EN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_ADDR
`ifdef FETCH_PERF_CNT_EN
  ,output logic [15:0]          STALL_CNT
`endif
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_infl;
  logic [ADDR_WIDTH-1:0] r_tag;
  logic [ADDR_WIDTH-1:0] r_faddr [2];
  logic [7:0]            r_fdata [2];
  logic [1:0]            r_cnt;

  logic                  w_pop;
  logic [1:0]            w_wr_idx;
  logic [2:0]            w_occ;
  logic                  w_issue;

  assign w_pop    = INSTR_VALID && INSTR_READY;
  assign w_wr_idx = r_cnt - {1'b0, w_pop};
  assign w_occ    = {1'b0, r_cnt} + {2'b0, r_infl} - {2'b0, w_pop};
  assign w_issue  = !BRANCH_EN && (w_occ < 3'(BUF_DEPTH));

  // Head of the buffer goes straight to the decoder.
  always_comb begin
    INSTR       = r_fdata[0];
    INSTR_ADDR  = r_faddr[0];
    INSTR_VALID = (r_cnt != 2'd0);
  end

  // ROM address: forced to zero in reset, branch target overrides PC.
  always_comb begin
    ROM_ADDR = r_pc;
    if (!RESETN)
      ROM_ADDR = '0;
    else if (BRANCH_EN)
      ROM_ADDR = BRANCH_ADDR;
  end

  // PC, in-flight tracking and buffer update; branch flushes everything.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_pc       <= '0;
      r_infl     <= 1'b0;
      r_tag      <= '0;
      r_cnt      <= 2'd0;
      r_faddr[0] <= '0;
      r_faddr[1] <= '0;
      r_fdata[0] <= '0;
      r_fdata[1] <= '0;
    end else if (BRANCH_EN) begin
      r_cnt  <= 2'd0;
      r_infl <= 1'b1;
      r_tag  <= BRANCH_ADDR;
      r_pc   <= BRANCH_ADDR + 1'b1;
    end else begin
      if (w_pop) begin
        r_faddr[0] <= r_faddr[1];
        r_fdata[0] <= r_fdata[1];
      end
      // Push after the shift so a same-slot write wins.
      if (r_infl) begin
        r_faddr[w_wr_idx[0]] <= r_tag;
        r_fdata[w_wr_idx[0]] <= ROM_DATA;
      end
      r_cnt  <= w_wr_idx + {1'b0, r_infl};
      r_infl <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        r_pc  <= r_pc + 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall;

  // Count cycles where a valid head waits on the decoder, saturating.
  always_ff @(posedge CLK) begin
    if (!RESETN)
      r_stall <= 16'd0;
    else if (INSTR_VALID && !INSTR_READY && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  assign STALL_CNT = r_stall;
`else
`endif

endmodule
